multi_clk_div: RTL and testbench

- Parametrised N-channel clock/tick divider. It is the successor to the fixed divide-by-50 RTC counter in the FPGA top level.
- Each channel divides the SoC clock by a runtime-programmable ratio and produces two outputs: a flop-driven divided clock (high phase = ceil(div/2)) and a one-cycle tick at each rising edge.
- Divisor updates are glitch-free and take effect only at a period boundary. A global sync realigns all channels.
- Used for the RTC, fan PWM timebase and peripheral tick generation.

---
 rtl/multi_clk_div.sv | 52 +++++
 tb/tb_multi_clk_div.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multi_clk_div.sv
// multi_clk_div: N-channel programmable clock/tick divider with glitch-free divisor updates and global sync
module multi_clk_div #(
  parameter int NumChannels = 2,
  parameter int DivWidth    = 16,
  parameter int DefaultDiv  = 50
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumChannels-1:0]          en_i,
  input  logic [NumChannels*DivWidth-1:0] div_i,
  input  logic [NumChannels-1:0]          div_valid_i,
  output logic [NumChannels-1:0]          div_ready_o,
  input  logic                            sync_i,
  output logic [NumChannels-1:0]          clk_o,
  output logic [NumChannels-1:0]          tick_o
);
  localparam logic [DivWidth-1:0] DefDiv = DivWidth'((DefaultDiv < 2) ? 2 : DefaultDiv);
  genvar c;
  for (c = 0; c < NumChannels; c++) begin : g_ch
    logic [DivWidth-1:0] active_q, pend_q, cnt_q, din, new_div, hi, nxt, next_active;
    logic pend_valid_q, clk_q, tick_q, wrap, apply, take;
    assign din         = div_i[c*DivWidth +: DivWidth];
    assign new_div     = (din < DivWidth'(2)) ? DivWidth'(2) : din;
    assign hi          = active_q - (active_q >> 1);
    assign nxt         = cnt_q + DivWidth'(1);
    assign wrap        = en_i[c] & ((cnt_q == active_q - DivWidth'(1)) | sync_i);
    assign apply       = pend_valid_q & (~en_i[c] | wrap);
    assign take        = div_valid_i[c] & ~pend_valid_q;
    assign next_active = apply ? pend_q : active_q;
    // Counter, phase and shadow-divisor update; idle preloads the last count so enabling wraps at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        active_q     <= DefDiv;
        pend_q       <= DefDiv;
        pend_valid_q <= 1'b0;
        cnt_q        <= DefDiv - DivWidth'(1);
        clk_q        <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        active_q     <= next_active;
        pend_valid_q <= take | (pend_valid_q & ~apply);
        if (take) pend_q <= new_div;
        cnt_q        <= !en_i[c] ? next_active - DivWidth'(1) : wrap ? '0 : nxt;
        clk_q        <= en_i[c] & (wrap | (nxt < hi));
        tick_q       <= wrap;
      end
    end
    assign div_ready_o[c] = ~pend_valid_q;
    assign clk_o[c]       = clk_q;
    assign tick_o[c]      = tick_q;
  end
endmodule

// File: tb/tb_multi_clk_div.sv
// tb_multi_clk_div: directed self-checking bench for multi_clk_div
module tb_multi_clk_div;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  en = '0;
  logic [31:0] div = '0;
  logic [1:0]  div_valid = '0;
  logic [1:0]  div_ready;
  logic        sync = 1'b0;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  int checks = 0;
  int errors = 0;
  int h, p, n;

  multi_clk_div #(.NumChannels(2), .DivWidth(16), .DefaultDiv(50)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .div_i(div), .div_valid_i(div_valid),
    .div_ready_o(div_ready), .sync_i(sync), .clk_o(clk_out), .tick_o(tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input int ch, output int cnt);
    cnt = 0;
    while (!tick[ch] && cnt < 70000) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic measure(input int ch, output int hi_len, output int per);
    hi_len = 0;
    per = 0;
    do begin
      if (clk_out[ch]) hi_len++;
      per++;
      step(1);
    end while (!tick[ch] && per < 70000);
  endtask

  initial begin
    #2;
    check("rst_clk", 32'(clk_out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_ready", 32'(div_ready), 3);
    step(1);
    rst_n = 1'b1;
    step(2);
    en = 2'b01;
    step(1);
    check("en_clk", 32'(clk_out[0]), 1);
    check("en_tick", 32'(tick[0]), 1);
    measure(0, h, p);
    check("d50_hi", h, 25);
    check("d50_per", p, 50);

    step(10);
    div[15:0] = 16'd5;
    div_valid = 2'b01;
    step(1);
    div_valid = 2'b00;
    check("upd_ready_low", 32'(div_ready[0]), 0);
    wait_tick(0, n);
    check("upd_old_finish", n, 39);
    check("upd_ready_high", 32'(div_ready[0]), 1);
    measure(0, h, p);
    check("d5_hi", h, 3);
    check("d5_per", p, 5);

    div[15:0] = 16'd0;
    div_valid = 2'b01;
    step(1);
    div_valid = 2'b00;
    wait_tick(0, n);
    check("d0_wait", n, 4);
    measure(0, h, p);
    check("d0_hi", h, 1);
    check("d0_per", p, 2);
    div[15:0] = 16'd1;
    div_valid = 2'b01;
    step(1);
    div_valid = 2'b00;
    wait_tick(0, n);
    check("d1_wait", n, 1);
    measure(0, h, p);
    check("d1_hi", h, 1);
    check("d1_per", p, 2);

    div[15:0] = 16'd7;
    div_valid = 2'b01;
    step(1);
    div[15:0] = 16'd3;
    step(1);
    div_valid = 2'b00;
    check("dbl_tick", 32'(tick[0]), 1);
    measure(0, h, p);
    check("dbl_hi", h, 4);
    check("dbl_per", p, 7);

    div[31:16] = 16'd10;
    div_valid = 2'b10;
    step(1);
    div_valid = 2'b00;
    check("idle_ready_low", 32'(div_ready[1]), 0);
    step(1);
    check("idle_ready_high", 32'(div_ready), 3);
    en = 2'b11;
    step(1);
    check("idle_en_tick", 32'(tick[1]), 1);
    measure(1, h, p);
    check("idle_d10_hi", h, 5);
    check("idle_d10_per", p, 10);

    step(3);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("sync_tick", 32'(tick), 3);
    check("sync_clk", 32'(clk_out), 3);
    step(9);
    check("sync_pre_tick", 32'(tick), 0);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("sync_nat_tick", 32'(tick), 3);
    step(1);
    check("sync_single", 32'(tick), 0);
    wait_tick(1, n);
    check("sync_after_per", n, 9);

    div[15:0] = 16'hFFFF;
    div_valid = 2'b01;
    step(1);
    div_valid = 2'b00;
    wait_tick(0, n);
    measure(0, h, p);
    check("dmax_hi", h, 32768);
    check("dmax_per", p, 65535);

    div[15:0] = 16'd9;
    div_valid = 2'b01;
    step(1);
    div_valid = 2'b00;
    check("rst_pend_ready", 32'(div_ready[0]), 0);
    step(3);
    check("rst_pre_clk", 32'(clk_out[0]), 1);
    rst_n = 1'b0;
    en = 2'b00;
    #1;
    check("arst_clk", 32'(clk_out), 0);
    check("arst_tick", 32'(tick), 0);
    check("arst_ready", 32'(div_ready), 3);
    step(2);
    rst_n = 1'b1;
    step(1);
    en = 2'b01;
    step(1);
    check("rel_tick", 32'(tick[0]), 1);
    measure(0, h, p);
    check("rel_hi", h, 25);
    check("rel_per", p, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
